ws2812_frame_ctrl: RTL

Frame-level sequencer for a WS2812-style GRB LED strip. On a start pulse it fetches one 24-bit GRB word per LED from an upstream pixel source over a req/ack handshake. It serialises each word MSB-first onto the single-wire data line with per-bit high/low timing, then holds the line low for the latch period and signals done. It owns the LED index counter, the bit counter and the bit-timing counter, and sits between the colour/animation logic and the strip output pin.

---
 rtl/ws2812_pkg.sv | 27 ++
 rtl/ws2812_bit_timer.sv | 60 ++++++
 rtl/ws2812_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame controller.
// Holds the FSM state encoding, GRB word and bit-counter widths,
// default 50 MHz timing constants and a small width helper.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_e;

  localparam int unsigned GRB_W     = 24;
  localparam int unsigned BIT_CNT_W = 5;

  // Defaults for a 50 MHz clock
  localparam int unsigned DEF_NUM_LEDS = 10;
  localparam int unsigned DEF_T0H      = 20;
  localparam int unsigned DEF_T1H      = 40;
  localparam int unsigned DEF_TBIT     = 63;
  localparam int unsigned DEF_TRESET   = 2500;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit timing generator for the WS2812 data line.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   i_load         - start a new bit period next cycle (timer restarts at 0)
//   i_run          - continue the current bit period
//   i_bit_val      - value of the bit being started by i_load
//   o_dout_hi      - registered line level for the current timer value
//   o_bit_end_c    - current cycle is the last cycle of the bit period
// With neither i_load nor i_run the timer parks at 0 and the line is low.
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H     = DEF_T0H,
  parameter int unsigned T1H     = DEF_T1H,
  parameter int unsigned TBIT    = DEF_TBIT,
  parameter int unsigned TIMER_W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_run,
  input  logic i_bit_val,
  output logic o_dout_hi,
  output logic o_bit_end_c
);

  localparam logic [TIMER_W-1:0] T0H_C  = TIMER_W'(T0H);
  localparam logic [TIMER_W-1:0] T1H_C  = TIMER_W'(T1H);
  localparam logic [TIMER_W-1:0] TEND_C = TIMER_W'(TBIT - 1);

  logic [TIMER_W-1:0] r_timer;
  logic               r_bit_val;
  logic               r_dout_hi;
  logic [TIMER_W-1:0] w_timer_inc;

  assign w_timer_inc = r_timer + TIMER_W'(1);

  // Line level is computed for the timer value being entered, so it is registered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer   <= '0;
      r_bit_val <= 1'b0;
      r_dout_hi <= 1'b0;
    end else if (i_load) begin
      r_timer   <= '0;
      r_bit_val <= i_bit_val;
      r_dout_hi <= ('0 < (i_bit_val ? T1H_C : T0H_C));
    end else if (i_run) begin
      r_timer   <= w_timer_inc;
      r_dout_hi <= (w_timer_inc < (r_bit_val ? T1H_C : T0H_C));
    end else begin
      r_timer   <= '0;
      r_dout_hi <= 1'b0;
    end
  end

  assign o_dout_hi   = r_dout_hi;
  assign o_bit_end_c = (r_timer == TEND_C);

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Frame sequencer for a WS2812 GRB LED strip: fetches one GRB word per LED
// over a req/ack handshake, shifts it out MSB-first with per-bit timing,
// then holds the line low for the latch period and pulses done.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_start     - one-cycle pulse, begins a frame when idle
//   o_busy      - frame in progress, through the done cycle inclusive
//   o_done      - one-cycle pulse at end of latch period
//   o_pix_req   - request GRB word for o_pix_idx
//   o_pix_idx   - LED index being requested
//   i_pix_ack   - i_pix_grb valid, completes the request
//   i_pix_grb   - {G,R,B} colour word
//   o_dout      - serial data to strip
// Build option WS_PREFETCH_EN: request LED n+1 while LED n is shifting,
// removing the inter-LED gap when the ack arrives in time.
module ws2812_frame_ctrl
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_LEDS = DEF_NUM_LEDS,
  parameter int unsigned T0H      = DEF_T0H,
  parameter int unsigned T1H      = DEF_T1H,
  parameter int unsigned TBIT     = DEF_TBIT,
  parameter int unsigned TRESET   = DEF_TRESET,
  localparam int unsigned IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pix_req,
  output logic [IDX_W-1:0] o_pix_idx,
  input  logic             i_pix_ack,
  input  logic [GRB_W-1:0] i_pix_grb,
  output logic             o_dout
);

  localparam int unsigned TIMER_W = $clog2(max_u(TBIT, TRESET));

  state_e               r_state,     w_state_nxt;
  logic [IDX_W-1:0]     r_led_idx,   w_led_idx_nxt;
  logic [IDX_W-1:0]     r_pix_idx,   w_pix_idx_nxt;
  logic                 r_pix_req,   w_pix_req_nxt;
  logic                 r_busy,      w_busy_nxt;
  logic                 r_done,      w_done_nxt;
  logic [GRB_W-1:0]     r_shift,     w_shift_nxt;
  logic [BIT_CNT_W-1:0] r_bit_cnt,   w_bit_cnt_nxt;
  logic [TIMER_W-1:0]   r_latch_cnt, w_latch_cnt_nxt;
`ifdef WS_PREFETCH_EN
  logic [GRB_W-1:0]     r_hold,      w_hold_nxt;
  logic                 r_hold_vld,  w_hold_vld_nxt;
  logic [GRB_W-1:0]     w_next_grb;
  logic [IDX_W-1:0]     w_led_inc2;
`endif

  logic             w_ack;
  logic             w_last_led;
  logic [IDX_W-1:0] w_led_inc;
  logic             w_tmr_load;
  logic             w_tmr_run;
  logic             w_tmr_bit;
  logic             w_dout_hi;
  logic             w_bit_end;

  assign w_ack      = r_pix_req & i_pix_ack;
  assign w_last_led = (r_led_idx == IDX_W'(NUM_LEDS - 1));
  assign w_led_inc  = r_led_idx + IDX_W'(1);
`ifdef WS_PREFETCH_EN
  assign w_led_inc2 = w_led_inc + IDX_W'(1);
  // Prefer the held word; an ack landing on the boundary cycle is used directly
  assign w_next_grb = r_hold_vld ? r_hold : i_pix_grb;
`endif

  ws2812_bit_timer #(
    .T0H     (T0H),
    .T1H     (T1H),
    .TBIT    (TBIT),
    .TIMER_W (TIMER_W)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_tmr_load),
    .i_run       (w_tmr_run),
    .i_bit_val   (w_tmr_bit),
    .o_dout_hi   (w_dout_hi),
    .o_bit_end_c (w_bit_end)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_led_idx   <= '0;
      r_pix_idx   <= '0;
      r_pix_req   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_latch_cnt <= '0;
`ifdef WS_PREFETCH_EN
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_led_idx   <= w_led_idx_nxt;
      r_pix_idx   <= w_pix_idx_nxt;
      r_pix_req   <= w_pix_req_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_latch_cnt <= w_latch_cnt_nxt;
`ifdef WS_PREFETCH_EN
      r_hold      <= w_hold_nxt;
      r_hold_vld  <= w_hold_vld_nxt;
`endif
    end
  end

  // Next-state, counters and timer control
  always_comb begin
    w_state_nxt     = r_state;
    w_led_idx_nxt   = r_led_idx;
    w_pix_idx_nxt   = r_pix_idx;
    w_pix_req_nxt   = r_pix_req;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_shift_nxt     = r_shift;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_latch_cnt_nxt = r_latch_cnt;
    w_tmr_load      = 1'b0;
    w_tmr_run       = 1'b0;
    w_tmr_bit       = 1'b0;
`ifdef WS_PREFETCH_EN
    w_hold_nxt      = r_hold;
    w_hold_vld_nxt  = r_hold_vld;
`endif

    case (r_state)
      IDLE: begin
        // busy is still high during the done cycle; it drops here
        w_busy_nxt = 1'b0;
        if (i_start && !r_busy) begin
          w_state_nxt     = FETCH;
          w_led_idx_nxt   = '0;
          w_pix_idx_nxt   = '0;
          w_pix_req_nxt   = 1'b1;
          w_busy_nxt      = 1'b1;
          w_bit_cnt_nxt   = '0;
          w_latch_cnt_nxt = '0;
        end
      end

      FETCH: begin
        if (w_ack) begin
          w_state_nxt   = SEND;
          w_shift_nxt   = i_pix_grb;
          w_bit_cnt_nxt = '0;
          w_pix_req_nxt = 1'b0;
          w_tmr_load    = 1'b1;
          w_tmr_bit     = i_pix_grb[GRB_W-1];
`ifdef WS_PREFETCH_EN
          w_hold_vld_nxt = 1'b0;
          if (!w_last_led) begin
            w_pix_req_nxt = 1'b1;
            w_pix_idx_nxt = w_led_inc;
          end
`endif
        end
      end

      SEND: begin
`ifdef WS_PREFETCH_EN
        if (w_ack) begin
          w_hold_nxt     = i_pix_grb;
          w_hold_vld_nxt = 1'b1;
          w_pix_req_nxt  = 1'b0;
        end
`endif
        if (w_bit_end) begin
          w_shift_nxt   = {r_shift[GRB_W-2:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
          if (r_bit_cnt == BIT_CNT_W'(GRB_W - 1)) begin
            if (w_last_led) begin
              w_state_nxt     = LATCH;
              w_latch_cnt_nxt = '0;
            end else begin
              w_led_idx_nxt = w_led_inc;
`ifdef WS_PREFETCH_EN
              if (r_hold_vld || w_ack) begin
                w_shift_nxt    = w_next_grb;
                w_bit_cnt_nxt  = '0;
                w_tmr_load     = 1'b1;
                w_tmr_bit      = w_next_grb[GRB_W-1];
                w_hold_vld_nxt = 1'b0;
                w_pix_req_nxt  = 1'b0;
                if (w_led_inc != IDX_W'(NUM_LEDS - 1)) begin
                  w_pix_req_nxt = 1'b1;
                  w_pix_idx_nxt = w_led_inc2;
                end
              end else begin
                // Request for this LED is already outstanding
                w_state_nxt = FETCH;
              end
`else
              w_state_nxt   = FETCH;
              w_pix_req_nxt = 1'b1;
              w_pix_idx_nxt = w_led_inc;
`endif
            end
          end else begin
            w_tmr_load = 1'b1;
            w_tmr_bit  = r_shift[GRB_W-2];
          end
        end else begin
          w_tmr_run = 1'b1;
        end
      end

      LATCH: begin
        if (r_latch_cnt == TIMER_W'(TRESET - 1)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_latch_cnt_nxt = r_latch_cnt + TIMER_W'(1);
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_pix_req = r_pix_req;
  assign o_pix_idx = r_pix_idx;
  assign o_dout    = w_dout_hi;

endmodule
